tea_dec_stream: RTL and testbench

//  Byte-stream front/back end for the combinational 32-round TEA decryptor (decryptor core).

---
 rtl/tea_dec_stream.sv | 143 ++++++++++++++
 tb/tb_tea_dec_stream.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tea_dec_stream.sv
// tea_dec_stream: byte-stream wrapper around a combinational TEA decryptor.
// Collects 8 ciphertext bytes, holds the core inputs, then emits 8 plaintext bytes.
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   key_in/key_load 128-bit key and its capture strobe (only at block start)
//   in_data/valid/ready    ciphertext byte stream (valid/ready handshake)
//   dec_block/dec_key      registered inputs to the decryptor core
//   dec_result             combinational result from the core
//   out_data/valid/ready   plaintext byte stream (valid/ready handshake)
//   busy            high while waiting on the core or emitting bytes
module tea_dec_stream #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_load,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [63:0]  dec_block,
  output logic [127:0] dec_key,
  input  logic [63:0]  dec_result,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_COLLECT,
    S_WAIT,
    S_EMIT
  } state_t;

  localparam logic [3:0] LP_SETTLE = 4'(SETTLE_CYCLES);

  state_t       r_state;
  state_t       w_next;
  logic [2:0]   r_byte_cnt;
  logic [3:0]   r_settle_cnt;
  logic [63:0]  r_block;
  logic [127:0] r_key;
  logic [63:0]  r_result;

  logic         w_in_xfer;
  logic         w_out_xfer;
  logic         w_last;
  logic [2:0]   w_lane;
  logic         w_capture;
  logic         w_key_ok;

  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;
  assign w_last     = (r_byte_cnt == 3'd7);

  // Stream byte i lands in 64-bit byte lane {i[2], ~i[1:0]}:
  // b0..b3 fill [31:0] MSB first, b4..b7 fill [63:32].
  assign w_lane = {r_byte_cnt[2], ~r_byte_cnt[1:0]};

  // Counter restarts at the b7 edge, so the capture lands
  // SETTLE_CYCLES+1 edges later; the core sees stable inputs
  // for at least SETTLE_CYCLES full cycles.
  assign w_capture = (r_state == S_WAIT) &&
                     (r_settle_cnt == LP_SETTLE);

  assign w_key_ok = key_load && (r_state == S_COLLECT) &&
                    (r_byte_cnt == 3'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (r_state)
      S_COLLECT: begin
        in_ready = 1'b1;
        if (in_valid && w_last) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (w_capture) begin
          w_next = S_EMIT;
        end
      end
      S_EMIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready && w_last) begin
          w_next = S_COLLECT;
        end
      end
      default: begin
        w_next = S_COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_byte_cnt   <= '0;
      r_settle_cnt <= '0;
      r_block      <= '0;
      r_key        <= '0;
      r_result     <= '0;
    end else begin
      if (w_in_xfer || w_out_xfer) begin
        r_byte_cnt <= r_byte_cnt + 3'd1;
      end
      if (w_in_xfer) begin
        r_block[{w_lane, 3'b000} +: 8] <= in_data;
      end
      if (w_key_ok) begin
        r_key <= key_in;
      end
      if (w_in_xfer && w_last) begin
        r_settle_cnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_settle_cnt <= r_settle_cnt + 4'd1;
      end
      if (w_capture) begin
        r_result <= dec_result;
      end
    end
  end

  assign dec_block = r_block;
  assign dec_key   = r_key;
  assign out_data  = out_valid ? r_result[{w_lane, 3'b000} +: 8]
                               : 8'h00;

endmodule

// File: tb/tb_tea_dec_stream.sv
// Bench for tea_dec_stream: three builds (settle 4, 1, 15), each wired to
// a behavioural TEA core, checked against a stream-level TEA reference.
module tb_tea_dec_stream;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;

  logic         kl[3];
  logic [7:0]   id[3];
  logic         iv[3];
  logic         ir[3];
  logic [63:0]  dblk[3];
  logic [127:0] dkey[3];
  logic [63:0]  dres[3];
  logic [7:0]   od[3];
  logic         ov[3];
  logic         orr[3];
  logic         bsy[3];

  logic [127:0] mkey[3];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Plain TEA decryption of one (v0, v1) word pair; returns {v0, v1}.
  function automatic logic [63:0] tea_words(input logic [31:0] a0,
                                            input logic [31:0] a1,
                                            input logic [127:0] k);
    logic [31:0] v0;
    logic [31:0] v1;
    logic [31:0] sum;
    v0  = a0;
    v1  = a1;
    sum = 32'hC6EF3720;
    for (int r = 0; r < 32; r++) begin
      v1 -= ((v0 << 4) + k[63:32]) ^ (v0 + sum) ^ ((v0 >> 5) + k[31:0]);
      v0 -= ((v1 << 4) + k[127:96]) ^ (v1 + sum) ^ ((v1 >> 5) + k[95:64]);
      sum -= 32'h9E3779B9;
    end
    return {v0, v1};
  endfunction

  // Core stand-in: inBlock64 holds V0 in [31:0], V1 in [63:32].
  function automatic logic [63:0] core(input logic [63:0] b,
                                       input logic [127:0] k);
    logic [63:0] w;
    w = tea_words(b[31:0], b[63:32], k);
    return {w[31:0], w[63:32]};
  endfunction

  // Reference on the byte stream: first 4 bytes are V0, next 4 V1.
  function automatic logic [63:0] ref_plain(input logic [63:0] c,
                                            input logic [127:0] k);
    return tea_words(c[63:32], c[31:0], k);
  endfunction

  assign dres[0] = core(dblk[0], dkey[0]);
  assign dres[1] = core(dblk[1], dkey[1]);
  assign dres[2] = core(dblk[2], dkey[2]);

  tea_dec_stream #(.SETTLE_CYCLES(4)) u_dut4 (
    .clk(clk), .rst(rst), .key_in(key_in), .key_load(kl[0]),
    .in_data(id[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .dec_block(dblk[0]), .dec_key(dkey[0]), .dec_result(dres[0]),
    .out_data(od[0]), .out_valid(ov[0]), .out_ready(orr[0]),
    .busy(bsy[0])
  );

  tea_dec_stream #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .key_in(key_in), .key_load(kl[1]),
    .in_data(id[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .dec_block(dblk[1]), .dec_key(dkey[1]), .dec_result(dres[1]),
    .out_data(od[1]), .out_valid(ov[1]), .out_ready(orr[1]),
    .busy(bsy[1])
  );

  tea_dec_stream #(.SETTLE_CYCLES(15)) u_dut15 (
    .clk(clk), .rst(rst), .key_in(key_in), .key_load(kl[2]),
    .in_data(id[2]), .in_valid(iv[2]), .in_ready(ir[2]),
    .dec_block(dblk[2]), .dec_key(dkey[2]), .dec_result(dres[2]),
    .out_data(od[2]), .out_valid(ov[2]), .out_ready(orr[2]),
    .busy(bsy[2])
  );

  // Feed nb bytes of stream word c (byte i = c[63-8i -: 8]).
  task automatic send_block(input int u, input logic [63:0] c,
                            input int nb,
                            input bit kl_first, input logic [127:0] kf,
                            input bit kl_mid, input logic [127:0] km);
    int i = 0;
    int guard = 0;
    bit first = 1'b1;
    bit mid_done = 1'b0;
    while (i < nb && guard < 200) begin
      @(negedge clk);
      guard++;
      if (first) begin
        checks++;
        if (ir[u] !== 1'b1 || ov[u] !== 1'b0) begin
          errors++;
          $display("FAIL start_ready u%0d in_ready=%b out_valid=%b need 1/0",
                   u, ir[u], ov[u]);
        end
      end
      kl[u] = 1'b0;
      if (first && kl_first) begin
        key_in  = kf;
        kl[u]   = 1'b1;
        mkey[u] = kf;
      end
      if (kl_mid && i == 3 && !mid_done) begin
        key_in   = km;
        kl[u]    = 1'b1;
        mid_done = 1'b1;
      end
      iv[u] = first || ($urandom_range(3) != 0);
      id[u] = c[63-8*i -: 8];
      first = 1'b0;
      if (iv[u] && ir[u]) i++;
    end
    checks++;
    if (i != nb) begin
      errors++;
      $display("FAIL send_timeout u%0d sent=%0d need %0d", u, i, nb);
    end
  endtask

  // Drain nb bytes, checking latency, core inputs, order and stall hold.
  task automatic recv_block(input int u, input logic [63:0] exp,
                            input int nb, input int exp_lat,
                            input bit stall, input bit hold_iv,
                            input logic [63:0] exp_blk);
    int got = 0;
    int guard = 0;
    int lat = 0;
    int k = 0;
    bit seen = 1'b0;
    bit prev_stall = 1'b0;
    logic [7:0] prev = 8'h00;
    while (got < nb && guard < 300) begin
      @(negedge clk);
      guard++;
      kl[u] = 1'b0;
      iv[u] = hold_iv;
      if (hold_iv) begin
        checks++;
        if (ir[u] !== 1'b0 || bsy[u] !== 1'b1) begin
          errors++;
          $display("FAIL busy_block u%0d in_ready=%b busy=%b need 0/1",
                   u, ir[u], bsy[u]);
        end
      end
      orr[u] = stall ? ((k % 4) == 0 || (k % 4) == 3) : 1'b1;
      k++;
      if (!seen) begin
        if (ov[u]) begin
          seen = 1'b1;
          if (exp_lat >= 0) begin
            checks++;
            if (lat != exp_lat) begin
              errors++;
              $display("FAIL latency u%0d got=%0d need %0d", u, lat, exp_lat);
            end
          end
          checks++;
          if (dblk[u] !== exp_blk || dkey[u] !== mkey[u]) begin
            errors++;
            $display("FAIL core_inputs u%0d blk=%h key=%h need %h %h",
                     u, dblk[u], dkey[u], exp_blk, mkey[u]);
          end
        end else begin
          lat++;
        end
      end
      if (ov[u]) begin
        if (prev_stall) begin
          checks++;
          if (od[u] !== prev) begin
            errors++;
            $display("FAIL stall_hold u%0d data=%h need %h", u, od[u], prev);
          end
        end
        if (orr[u]) begin
          checks++;
          if (od[u] !== exp[63-8*got -: 8]) begin
            errors++;
            $display("FAIL out_byte u%0d idx=%0d got=%h need %h",
                     u, got, od[u], exp[63-8*got -: 8]);
          end
          got++;
        end
        prev_stall = !orr[u];
        prev = od[u];
      end
    end
    checks++;
    if (got != nb) begin
      errors++;
      $display("FAIL recv_timeout u%0d got=%0d need %0d", u, got, nb);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    for (int u = 0; u < 3; u++) begin
      checks++;
      if (ir[u] !== 1'b1 || ov[u] !== 1'b0 || od[u] !== 8'h00 ||
          bsy[u] !== 1'b0 || dblk[u] !== 64'h0 || dkey[u] !== 128'h0) begin
        errors++;
        $display("FAIL reset u%0d rdy=%b ov=%b od=%h busy=%b blk=%h key=%h",
                 u, ir[u], ov[u], od[u], bsy[u], dblk[u], dkey[u]);
      end
      mkey[u] = '0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_known_vector();
    logic [63:0] c;
    c = 64'h41ea3a0a94baa940;
    send_block(0, c, 8, 1'b1, 128'h0, 1'b0, 128'h0);
    recv_block(0, 64'h0, 8, 5, 1'b0, 1'b0, 64'h94baa940_41ea3a0a);
  endtask

  task automatic test_back_to_back();
    logic [63:0]  c;
    logic [127:0] k;
    k = {$urandom, $urandom, $urandom, $urandom};
    for (int b = 0; b < 3; b++) begin
      c = {$urandom, $urandom};
      send_block(0, c, 8, b == 0, k, 1'b0, 128'h0);
      recv_block(0, ref_plain(c, mkey[0]), 8, 5, 1'b0, 1'b1,
                 {c[31:0], c[63:32]});
    end
    iv[0] = 1'b0;
  endtask

  task automatic test_out_stall();
    logic [63:0] c;
    c = {$urandom, $urandom};
    send_block(0, c, 8, 1'b0, 128'h0, 1'b0, 128'h0);
    recv_block(0, ref_plain(c, mkey[0]), 8, 5, 1'b1, 1'b0,
               {c[31:0], c[63:32]});
  endtask

  task automatic test_key_load();
    logic [63:0]  c;
    logic [127:0] k;
    c = {$urandom, $urandom};
    k = {$urandom, $urandom, $urandom, $urandom};
    send_block(0, c, 8, 1'b0, 128'h0, 1'b1, k);
    recv_block(0, ref_plain(c, mkey[0]), 8, 5, 1'b0, 1'b0,
               {c[31:0], c[63:32]});
    c = {$urandom, $urandom};
    k = {$urandom, $urandom, $urandom, $urandom};
    send_block(0, c, 8, 1'b1, k, 1'b0, 128'h0);
    recv_block(0, ref_plain(c, mkey[0]), 8, 5, 1'b0, 1'b0,
               {c[31:0], c[63:32]});
  endtask

  task automatic test_reset_mid();
    logic [63:0]  c;
    logic [127:0] k;
    for (int pass = 0; pass < 2; pass++) begin
      c = {$urandom, $urandom};
      if (pass == 0) begin
        send_block(0, c, 5, 1'b0, 128'h0, 1'b0, 128'h0);
      end else begin
        send_block(0, c, 8, 1'b0, 128'h0, 1'b0, 128'h0);
        recv_block(0, ref_plain(c, mkey[0]), 3, 5, 1'b0, 1'b0,
                   {c[31:0], c[63:32]});
      end
      @(posedge clk);
      #2 rst = 1'b0;
      iv[0] = 1'b0;
      kl[0] = 1'b0;
      #1;
      checks++;
      if (ir[0] !== 1'b1 || ov[0] !== 1'b0 || od[0] !== 8'h00 ||
          bsy[0] !== 1'b0 || dblk[0] !== 64'h0 || dkey[0] !== 128'h0) begin
        errors++;
        $display("FAIL reset_mid p%0d rdy=%b ov=%b od=%h busy=%b blk=%h key=%h",
                 pass, ir[0], ov[0], od[0], bsy[0], dblk[0], dkey[0]);
      end
      for (int u = 0; u < 3; u++) mkey[u] = '0;
      @(negedge clk);
      rst = 1'b1;
      c = {$urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      send_block(0, c, 8, 1'b1, k, 1'b0, 128'h0);
      recv_block(0, ref_plain(c, mkey[0]), 8, 5, 1'b0, 1'b0,
                 {c[31:0], c[63:32]});
    end
  endtask

  task automatic test_settle();
    logic [63:0]  c;
    logic [127:0] k;
    for (int u = 1; u < 3; u++) begin
      c = {$urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      send_block(u, c, 8, 1'b1, k, 1'b0, 128'h0);
      recv_block(u, ref_plain(c, mkey[u]), 8, (u == 1) ? 2 : 16,
                 1'b0, 1'b0, {c[31:0], c[63:32]});
    end
  endtask

  initial begin
    key_in = '0;
    for (int u = 0; u < 3; u++) begin
      kl[u]   = 1'b0;
      id[u]   = 8'h00;
      iv[u]   = 1'b0;
      orr[u]  = 1'b0;
      mkey[u] = '0;
    end
    test_reset();
    test_known_vector();
    test_back_to_back();
    test_out_stall();
    test_key_load();
    test_reset_mid();
    test_settle();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
